rca_writeback_result_queue: RTL and testbench

Unit-side source for the RCA writeback interface. It buffers completed RCA results (one instruction ID plus `NUM_WRITE_PORTS` destination values) in an in-order circular queue. It presents the head entry to the register-file/writeback stage through `done`/`id`/`rd` and retires the entry on `ack`. The block sits between the RCA compute pipeline and `rca_writeback_interface.wb`, and decouples RCA completion from writeback acceptance.

---
 rtl/rca_writeback_result_queue.sv | 108 ++++++++++
 tb/tb_rca_writeback_result_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rca_writeback_result_queue.sv
// rtl/rca_writeback_result_queue.sv - in-order result queue feeding the RCA writeback interface
//
// Buffers completed RCA results {id, rd[NUM_WRITE_PORTS]} in a circular queue
// and presents the head entry to the writeback stage until it is acknowledged.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   result_valid/_id/_data  result offered by the RCA pipeline
//   result_ready          queue has a free slot (registered state only)
//   rca_wb_done           head entry valid
//   rca_wb_id, rca_wb_rd  head entry contents, zero when rca_wb_done=0
//   rca_wb_ack            writeback accepts the head entry (ignored when done=0)
//   occupancy             number of entries currently held
//   overflow_error        sticky: a result was offered while the queue was full
module rca_writeback_result_queue #(
  parameter int DEPTH           = 4,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int XLEN            = 32,
  parameter int ID_W            = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  result_valid,
  input  logic [ID_W-1:0]                       result_id,
  input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  result_data,
  output logic                                  result_ready,
  output logic                                  rca_wb_done,
  output logic [ID_W-1:0]                       rca_wb_id,
  output logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  rca_wb_rd,
  input  logic                                  rca_wb_ack,
  output logic [$clog2(DEPTH+1)-1:0]            occupancy,
  output logic                                  overflow_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(DEPTH + 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;

  logic [ID_W-1:0]                      id_mem_q [DEPTH];
  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd_mem_q [DEPTH];

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] occ_diff;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // result_ready depends only on registered state; a pop this cycle does not
  // open a slot for a push in the same cycle.
  assign result_ready = ~full;
  assign rca_wb_done  = ~empty;

  assign push = result_valid & result_ready;
  assign pop  = rca_wb_done & rca_wb_ack;

  // Modular subtraction stays correct across the pointer wrap.
  assign occ_diff  = wr_ptr_q - rd_ptr_q;
  assign occupancy = OW'(occ_diff);

  assign overflow_error = overflow_q;

  // Head entry is gated to zero when empty so stale storage never leaks out.
  always_comb begin
    rca_wb_id = '0;
    rca_wb_rd = '0;
    if (rca_wb_done) begin
      rca_wb_id = id_mem_q[rd_ptr_q[AW-1:0]];
      rca_wb_rd = rd_mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (result_valid & ~result_ready);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      id_mem_q[wr_ptr_q[AW-1:0]] <= result_id;
      rd_mem_q[wr_ptr_q[AW-1:0]] <= result_data;
    end
  end

endmodule

// File: tb/tb_rca_writeback_result_queue.sv
// tb/tb_rca_writeback_result_queue.sv - scoreboard bench for rca_writeback_result_queue
module tb_rca_writeback_result_queue;

  localparam int ID_W = 4;
  localparam int XLEN = 32;
  localparam int NWP  = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       result_valid;
  logic [ID_W-1:0]            result_id;
  logic [NWP-1:0][XLEN-1:0]   result_data;
  logic                       result_ready;
  logic                       rca_wb_done;
  logic [ID_W-1:0]            rca_wb_id;
  logic [NWP-1:0][XLEN-1:0]   rca_wb_rd;
  logic                       rca_wb_ack;
  logic [2:0]                 occupancy;
  logic                       overflow_error;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  logic [ID_W+2*XLEN-1:0] exp_q [$];

  rca_writeback_result_queue #(
    .DEPTH(4), .NUM_WRITE_PORTS(NWP), .XLEN(XLEN), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .result_valid(result_valid), .result_id(result_id), .result_data(result_data),
    .result_ready(result_ready),
    .rca_wb_done(rca_wb_done), .rca_wb_id(rca_wb_id), .rca_wb_rd(rca_wb_rd),
    .rca_wb_ack(rca_wb_ack),
    .occupancy(occupancy), .overflow_error(overflow_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: retire expected entries whenever the DUT hands one over.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (rca_wb_done && rca_wb_ack) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL retire_unexpected: got id %0h with nothing expected", rca_wb_id);
        end else begin
          logic [ID_W+2*XLEN-1:0] e;
          e = exp_q.pop_front();
          if ({rca_wb_id, rca_wb_rd[1], rca_wb_rd[0]} !== e) begin
            fails++;
            $display("FAIL retire_entry: got %0h expected %0h",
                     {rca_wb_id, rca_wb_rd[1], rca_wb_rd[0]}, e);
          end
        end
      end else if (!rca_wb_done) begin
        tests++;
        if (rca_wb_id !== '0 || rca_wb_rd !== '0) begin
          fails++;
          $display("FAIL idle_zero: got id %0h rd %0h expected 0", rca_wb_id, rca_wb_rd);
        end
      end
    end
  end

  // One clock of stimulus; acc says whether this offer is expected to be accepted.
  task automatic cyc(input logic v, input logic [ID_W-1:0] id, input logic [31:0] d0,
                     input logic [31:0] d1, input logic a, input logic acc);
    result_valid   = v;
    result_id      = id;
    result_data[0] = d0;
    result_data[1] = d1;
    rca_wb_ack     = a;
    if (acc) exp_q.push_back({id, d1, d0});
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ID_W-1:0] id, input logic a);
    cyc(1'b1, id, 32'h1000_0000 + 32'(id), 32'hBEEF_0000 + 32'(id), a, 1'b1);
  endtask

  task automatic idle(input logic a);
    cyc(1'b0, '0, '0, '0, a, 1'b0);
  endtask

  initial begin
    rst = 1'b1; result_valid = 1'b0; result_id = '0; result_data = '0; rca_wb_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_done", 32'(rca_wb_done), 0);
    check("rst_id", 32'(rca_wb_id), 0);
    check("rst_rd", 32'(rca_wb_rd[0] | rca_wb_rd[1]), 0);
    check("rst_ready", 32'(result_ready), 1);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_ovf", 32'(overflow_error), 0);
    mon_en = 1'b1;

    // single push/pop
    cyc(1'b1, 4'd3, 32'hA5A5_0001, 32'h0000_0002, 1'b0, 1'b1);
    check("single_done", 32'(rca_wb_done), 1);
    check("single_id", 32'(rca_wb_id), 3);
    check("single_rd0", rca_wb_rd[0], 32'hA5A5_0001);
    check("single_rd1", rca_wb_rd[1], 32'h0000_0002);
    check("single_occ1", 32'(occupancy), 1);
    idle(1'b1);
    check("single_done0", 32'(rca_wb_done), 0);
    check("single_occ0", 32'(occupancy), 0);

    // fill and overflow
    for (int i = 1; i <= 4; i++) push(ID_W'(i), 1'b0);
    check("fill_occ", 32'(occupancy), 4);
    check("fill_ready", 32'(result_ready), 0);
    check("fill_ovf0", 32'(overflow_error), 0);
    cyc(1'b1, 4'd5, 32'h5, 32'h5, 1'b1, 1'b0);
    check("ovf_occ", 32'(occupancy), 3);
    check("ovf_flag", 32'(overflow_error), 1);
    check("ovf_ready", 32'(result_ready), 1);
    idle(1'b0);
    check("ovf_sticky", 32'(overflow_error), 1);
    repeat (3) idle(1'b1);
    check("drain_occ", 32'(occupancy), 0);

    // wrap-around ordering
    push(4'd0, 1'b0);
    push(4'd1, 1'b0);
    check("wrap_occ_start", 32'(occupancy), 2);
    for (int i = 2; i <= 9; i++) begin
      push(ID_W'(i), 1'b1);
      check("wrap_occ", 32'(occupancy), 2);
    end
    idle(1'b1);
    check("wrap_occ_1", 32'(occupancy), 1);
    idle(1'b1);
    check("wrap_occ_0", 32'(occupancy), 0);
    check("wrap_done0", 32'(rca_wb_done), 0);

    // simultaneous push and pop
    push(4'd5, 1'b0);
    push(4'd6, 1'b0);
    push(4'd7, 1'b1);
    check("sim_occ", 32'(occupancy), 2);
    check("sim_head", 32'(rca_wb_id), 6);
    idle(1'b1);
    check("sim_head2", 32'(rca_wb_id), 7);
    idle(1'b1);
    check("sim_occ0", 32'(occupancy), 0);

    // reset mid-stream
    push(4'd1, 1'b0);
    push(4'd2, 1'b0);
    push(4'd3, 1'b0);
    check("mid_occ3", 32'(occupancy), 3);
    rst = 1'b1;
    cyc(1'b1, 4'd4, 32'h4, 32'h4, 1'b1, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    check("mid_done", 32'(rca_wb_done), 0);
    check("mid_occ", 32'(occupancy), 0);
    check("mid_ovf", 32'(overflow_error), 0);
    repeat (3) idle(1'b1);
    check("mid_stale_done", 32'(rca_wb_done), 0);
    push(4'd9, 1'b0);
    check("post_head", 32'(rca_wb_id), 9);
    idle(1'b1);
    idle(1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
